// File: rtl/core_pkg.sv
// Shared decode constants, ALU operation and FSM state types for multicycle_exec_core.
package core_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} fsm_state_t;

    // alt selects SUB/SRA over ADD/SRL (funct7 bit 5 or instr[30])
    function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational integer ALU; shift amount is 5 bits for XLEN=32 and 6 bits for XLEN=64.
module exec_alu
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);
    localparam int SW = (XLEN == 64) ? 6 : 5;

    logic [SW-1:0] shamt_s;
    assign shamt_s = b[SW-1:0];

    // Operation select
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << shamt_s;
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> shamt_s;
            ALU_SRA:    result = $unsigned($signed(a) >>> shamt_s);
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_exec_core.sv
// Multi-cycle RV32I/RV64I integer core: IDLE -> EXEC -> [MUL] -> WB, one retire pulse per instruction.
// Define RV_MUL_EN to add the iterative shift-add MUL instruction.
module multicycle_exec_core
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    output logic            retire_illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    localparam int AW = $clog2(REG_COUNT);

    fsm_state_t      state_r, next_state_s;
    logic [31:0]     instr_r;
    logic [XLEN-1:0] regs_r [REG_COUNT];
    logic            retire_valid_r, retire_illegal_r;
    logic [4:0]      retire_rd_r;
    logic [XLEN-1:0] retire_data_r;

    logic [6:0]      opcode_s, funct7_s;
    logic [2:0]      funct3_s;
    logic [4:0]      rd_s, rs1_s, rs2_s;
    logic            rd_ok_s, rs1_ok_s, rs2_ok_s, shamt_ok_s;
    logic [XLEN-1:0] rs1_val_s, rs2_val_s, imm_i_s, imm_u_s, b_s, alu_result_s;
    alu_op_t         alu_op_s;
    logic            illegal_s, mul_go_s;

    assign opcode_s = instr_r[6:0];
    assign rd_s     = instr_r[11:7];
    assign funct3_s = instr_r[14:12];
    assign rs1_s    = instr_r[19:15];
    assign rs2_s    = instr_r[24:20];
    assign funct7_s = instr_r[31:25];

    assign rd_ok_s    = ({1'b0, rd_s}  < 6'(REG_COUNT));
    assign rs1_ok_s   = ({1'b0, rs1_s} < 6'(REG_COUNT));
    assign rs2_ok_s   = ({1'b0, rs2_s} < 6'(REG_COUNT));
    assign shamt_ok_s = (XLEN == 64) || !instr_r[25];

    // x0 is never written, so its storage always reads as zero
    assign rs1_val_s = regs_r[rs1_s[AW-1:0]];
    assign rs2_val_s = regs_r[rs2_s[AW-1:0]];
    assign imm_i_s   = XLEN'($signed(instr_r[31:20]));
    assign imm_u_s   = XLEN'($signed({instr_r[31:12], 12'h000}));

    // Instruction decode and legality
    always_comb begin
        alu_op_s  = ALU_ADD;
        b_s       = rs2_val_s;
        illegal_s = 1'b1;
        mul_go_s  = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                if (funct7_s == F7_BASE) begin
                    alu_op_s  = f3_to_alu(funct3_s, 1'b0);
                    illegal_s = !(rd_ok_s && rs1_ok_s && rs2_ok_s);
                end else if (funct7_s == F7_ALT &&
                             (funct3_s == F3_ADD_SUB || funct3_s == F3_SRL_SRA)) begin
                    alu_op_s  = f3_to_alu(funct3_s, 1'b1);
                    illegal_s = !(rd_ok_s && rs1_ok_s && rs2_ok_s);
`ifdef RV_MUL_EN
                end else if (funct7_s == F7_MULDIV && funct3_s == F3_ADD_SUB) begin
                    illegal_s = !(rd_ok_s && rs1_ok_s && rs2_ok_s);
                    mul_go_s  = rd_ok_s && rs1_ok_s && rs2_ok_s;
`endif
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                b_s = imm_i_s;
                if (funct3_s == F3_SLL) begin
                    alu_op_s  = ALU_SLL;
                    illegal_s = !(rd_ok_s && rs1_ok_s && shamt_ok_s && instr_r[31:26] == 6'b000000);
                end else if (funct3_s == F3_SRL_SRA) begin
                    alu_op_s  = f3_to_alu(funct3_s, instr_r[30]);
                    illegal_s = !(rd_ok_s && rs1_ok_s && shamt_ok_s &&
                                  (instr_r[31:26] == 6'b000000 || instr_r[31:26] == 6'b010000));
                end else begin
                    alu_op_s  = f3_to_alu(funct3_s, 1'b0);
                    illegal_s = !(rd_ok_s && rs1_ok_s);
                end
            end
            OPC_LUI: begin
                alu_op_s  = ALU_PASS_B;
                b_s       = imm_u_s;
                illegal_s = !rd_ok_s;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    exec_alu #(.XLEN(XLEN)) u_alu (
        .op     (alu_op_s),
        .a      (rs1_val_s),
        .b      (b_s),
        .result (alu_result_s)
    );

`ifdef RV_MUL_EN
    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] mcand_r, mplier_r, acc_r, acc_next_s;
    logic [CW-1:0]   cnt_r;
    logic            mul_done_s;

    assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : '0);
    assign mul_done_s = (cnt_r == CW'(XLEN - 1));

    // Shift-add multiplier: one multiplier bit per MUL cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (state_r == EXEC) begin
            mcand_r  <= rs1_val_s;
            mplier_r <= rs2_val_s;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (state_r == MUL) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= acc_next_s;
            cnt_r    <= cnt_r + CW'(1);
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (instr_valid) next_state_s = EXEC;
                else             next_state_s = IDLE;
            end
            EXEC: begin
`ifdef RV_MUL_EN
                if (mul_go_s) next_state_s = MUL;
                else          next_state_s = WB;
`else
                next_state_s = WB;
`endif
            end
`ifdef RV_MUL_EN
            MUL: begin
                if (mul_done_s) next_state_s = WB;
                else            next_state_s = MUL;
            end
`endif
            WB:      next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Instruction latch and registered retire port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r          <= 32'h0000_0000;
            retire_valid_r   <= 1'b0;
            retire_rd_r      <= 5'd0;
            retire_data_r    <= '0;
            retire_illegal_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: if (instr_valid) instr_r <= instr;
                EXEC: begin
                    retire_valid_r   <= !mul_go_s;
                    retire_rd_r      <= illegal_s ? 5'd0 : rd_s;
                    retire_data_r    <= illegal_s ? '0 : alu_result_s;
                    retire_illegal_r <= illegal_s;
                end
`ifdef RV_MUL_EN
                MUL: if (mul_done_s) begin
                    retire_valid_r <= 1'b1;
                    retire_data_r  <= acc_next_s;
                end
`endif
                WB: begin
                    retire_valid_r   <= 1'b0;
                    retire_rd_r      <= 5'd0;
                    retire_data_r    <= '0;
                    retire_illegal_r <= 1'b0;
                end
                default: retire_valid_r <= 1'b0;
            endcase
        end
    end

    // Register file: commit on the edge leaving WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs_r[i] <= '0;
        end else if (state_r == WB && retire_valid_r && !retire_illegal_r) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (retire_rd_r == 5'(i)) regs_r[i] <= retire_data_r;
            end
        end
    end

    // Debug read port
    always_comb begin
        if (dbg_addr != 5'd0 && {1'b0, dbg_addr} < 6'(REG_COUNT)) dbg_data = regs_r[dbg_addr[AW-1:0]];
        else                                                      dbg_data = '0;
    end

    assign instr_ready    = (state_r == IDLE);
    assign retire_valid   = retire_valid_r;
    assign retire_rd      = retire_rd_r;
    assign retire_data    = retire_data_r;
    assign retire_illegal = retire_illegal_r;

endmodule

// File: tb/tb_multicycle_exec_core.sv
// Self-checking bench for multicycle_exec_core (XLEN=32, REG_COUNT=16): directed table,
// randomized instructions against an architectural model, and reset-abort sequences.
module tb_multicycle_exec_core;
    localparam int XLEN = 32;
    localparam int RC   = 16;
`ifdef RV_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        instr_ready, retire_valid, retire_illegal;
    logic [4:0]  retire_rd, dbg_addr = 5'd0;
    logic [31:0] retire_data, dbg_data;

    multicycle_exec_core #(.XLEN(XLEN), .REG_COUNT(RC)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .retire_valid(retire_valid), .retire_rd(retire_rd),
        .retire_data(retire_data), .retire_illegal(retire_illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [31:0] mregs [32];

    typedef struct {
        logic [31:0] w;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        int          lat;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    // Architectural reference: RV32I semantics on an array of registers
    task automatic model(input logic [31:0] w, output logic [4:0] rd, output logic [31:0] data,
                         output logic ill, output int lat);
        int          rdi, r1, r2;
        logic [31:0] a, b, imm;
        rdi = int'(w[11:7]); r1 = int'(w[19:15]); r2 = int'(w[24:20]);
        a = mregs[r1]; b = mregs[r2]; imm = {{20{w[31]}}, w[31:20]};
        ill = 1'b1; data = 32'd0; lat = 2;
        if (w[6:0] == 7'h33 && rdi < RC && r1 < RC && r2 < RC) begin
            ill = 1'b0;
            case ({w[31:25], w[14:12]})
                10'b0000000_000: data = a + b;
                10'b0100000_000: data = a - b;
                10'b0000000_001: data = a << b[4:0];
                10'b0000000_010: data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                10'b0000000_011: data = (a < b) ? 32'd1 : 32'd0;
                10'b0000000_100: data = a ^ b;
                10'b0000000_101: data = a >> b[4:0];
                10'b0100000_101: data = $signed(a) >>> b[4:0];
                10'b0000000_110: data = a | b;
                10'b0000000_111: data = a & b;
                10'b0000001_000: begin
                    ill = !MUL_EN; data = a * b; lat = MUL_EN ? XLEN + 2 : 2;
                end
                default: ill = 1'b1;
            endcase
        end else if (w[6:0] == 7'h13 && rdi < RC && r1 < RC) begin
            ill = 1'b0;
            case (w[14:12])
                3'd0: data = a + imm;
                3'd2: data = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3: data = (a < imm) ? 32'd1 : 32'd0;
                3'd4: data = a ^ imm;
                3'd6: data = a | imm;
                3'd7: data = a & imm;
                3'd1: if (w[31:25] == 7'h00) data = a << w[24:20]; else ill = 1'b1;
                default: begin
                    if (w[31:25] == 7'h00)      data = a >> w[24:20];
                    else if (w[31:25] == 7'h20) data = $signed(a) >>> w[24:20];
                    else                        ill = 1'b1;
                end
            endcase
        end else if (w[6:0] == 7'h37 && rdi < RC) begin
            ill = 1'b0; data = {w[31:12], 12'h000};
        end
        if (ill) begin
            rd = 5'd0; data = 32'd0; lat = 2;
        end else begin
            rd = w[11:7];
            if (rdi != 0) mregs[rdi] = data;
        end
    endtask

    // Issue one instruction and collect its retire; optionally hold a junk offer while busy
    task automatic run(input logic [31:0] w, input bit junk, output logic [4:0] rd,
                       output logic [31:0] data, output logic ill, output int lat);
        int n = 0;
        while (!instr_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("ready_wait", instr_ready, 1);
        instr = w; instr_valid = 1'b1;
        @(posedge clk); #1;
        check("busy_ready", instr_ready, 0);
        if (junk) instr = enc_i(12'h055, 5'd0, 3'd0, 5'd7);
        else begin instr_valid = 1'b0; instr = $urandom; end
        lat = 1;
        while (!retire_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        rd = retire_rd; data = retire_data; ill = retire_illegal;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("pulse_end", retire_valid, 0);
        check("idle_ready", instr_ready, 1);
    endtask

    task automatic dbg_check(input logic [4:0] a);
        dbg_addr = a; #1;
        check($sformatf("dbg_x%0d", a), dbg_data, mregs[a]);
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 99) < 8) return 5'($urandom_range(16, 31));
        else                           return 5'($urandom_range(0, 15));
    endfunction

    function automatic logic [31:0] gen();
        logic [4:0]  rd, r1, r2;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [11:0] imm;
        rd = pick_reg(); r1 = pick_reg(); r2 = pick_reg();
        f3 = 3'($urandom_range(0, 7)); imm = 12'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
                case ($urandom_range(0, 5))
                    0, 1, 2: f7 = 7'h00;
                    3:       f7 = 7'h20;
                    4: begin f7 = 7'h01; if ($urandom_range(0, 1) == 1) f3 = 3'd0; end
                    default: f7 = 7'($urandom);
                endcase
                return enc_r(f7, r2, r1, f3, rd);
            end
            4, 5, 6: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    case ($urandom_range(0, 3))
                        0, 1:    imm[11:5] = 7'h00;
                        2:       imm[11:5] = 7'h20;
                        default: imm[11:5] = imm[11:5];
                    endcase
                end
                return enc_i(imm, r1, f3, rd);
            end
            7:       return {20'($urandom), rd, 7'h37};
            8:       return $urandom;
            default: return enc_i(imm, 5'd0, 3'd0, rd);
        endcase
    endfunction

    task automatic add_vec(input logic [31:0] w, input logic [4:0] rd, input logic [31:0] data,
                           input logic ill, input int lat);
        vec_t v;
        v.w = w; v.rd = rd; v.data = data; v.ill = ill; v.lat = lat;
        tbl.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  rd, mrd;
        logic [31:0] data, mdata;
        logic        ill, mill;
        int          lat, mlat;
        logic [31:0] w;

        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", instr_ready, 1);
        check("rst_valid", retire_valid, 0);
        check("rst_rd", retire_rd, 0);
        check("rst_data", retire_data, 0);
        check("rst_illegal", retire_illegal, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", instr_ready, 1);

        add_vec(32'hFFB00093, 5'd1, 32'hFFFFFFFB, 1'b0, 2);
        add_vec({20'h80000, 5'd1, 7'h37}, 5'd1, 32'h80000000, 1'b0, 2);
        add_vec(enc_i(12'h001, 5'd0, 3'd0, 5'd2), 5'd2, 32'h00000001, 1'b0, 2);
        add_vec(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3), 5'd3, 32'hC0000000, 1'b0, 2);
        add_vec(enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd4), 5'd4, 32'h40000000, 1'b0, 2);
        add_vec(enc_i(12'h007, 5'd0, 3'd0, 5'd0), 5'd0, 32'h00000007, 1'b0, 2);
        add_vec(enc_i(12'h001, 5'd0, 3'd0, 5'd20), 5'd0, 32'h0, 1'b1, 2);
        add_vec(32'h0000007F, 5'd0, 32'h0, 1'b1, 2);
        add_vec(enc_i(12'h021, 5'd1, 3'd1, 5'd5), 5'd0, 32'h0, 1'b1, 2);
        add_vec(enc_i(12'h007, 5'd0, 3'd0, 5'd1), 5'd1, 32'h00000007, 1'b0, 2);
        add_vec(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2), 5'd2, 32'hFFFFFFFD, 1'b0, 2);
        add_vec(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), MUL_EN ? 5'd3 : 5'd0,
                MUL_EN ? 32'hFFFFFFEB : 32'h0, !MUL_EN, MUL_EN ? XLEN + 2 : 2);
        add_vec(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd6), 5'd6, 32'h1, 1'b0, 2);
        add_vec(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd7), 5'd7, 32'h0, 1'b0, 2);
        add_vec(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd8), 5'd8, 32'h0000000A, 1'b0, 2);
        add_vec(enc_i(12'h401, 5'd2, 3'd5, 5'd9), 5'd9, 32'hFFFFFFFE, 1'b0, 2);
        add_vec(enc_r(7'h20, 5'd2, 5'd1, 3'd6, 5'd10), 5'd0, 32'h0, 1'b1, 2);

        foreach (tbl[k]) begin
            run(tbl[k].w, 1'b0, rd, data, ill, lat);
            model(tbl[k].w, mrd, mdata, mill, mlat);
            check($sformatf("vec%0d_rd", k), rd, tbl[k].rd);
            check($sformatf("vec%0d_data", k), data, tbl[k].data);
            check($sformatf("vec%0d_illegal", k), ill, tbl[k].ill);
            check($sformatf("vec%0d_latency", k), lat, tbl[k].lat);
            dbg_check(tbl[k].w[11:7]);
        end
        dbg_check(5'd0);
        dbg_check(5'd3);

        for (int n = 0; n < 250; n++) begin
            w = gen();
            run(w, (n % 7 == 3), rd, data, ill, lat);
            model(w, mrd, mdata, mill, mlat);
            check($sformatf("rand%0d_rd", n), rd, mrd);
            check($sformatf("rand%0d_data", n), data, mdata);
            check($sformatf("rand%0d_illegal", n), ill, mill);
            check($sformatf("rand%0d_latency", n), lat, mlat);
            dbg_check(5'($urandom_range(0, 31)));
            if (n % 7 == 3) dbg_check(5'd7);
        end

        // Reset during EXEC aborts the instruction
        instr = enc_i(12'h009, 5'd0, 3'd0, 5'd5); instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst_n = 1'b0; #1;
        check("abort_exec_ready", instr_ready, 1);
        check("abort_exec_valid", retire_valid, 0);
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        repeat (3) begin @(posedge clk); #1; check("abort_exec_no_pulse", retire_valid, 0); end
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) dbg_check(5'(i));

        // Reset during WB loses the pending write
        instr = enc_i(12'h009, 5'd0, 3'd0, 5'd6); instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("wb_pulse", retire_valid, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dbg_check(5'd6);
        check("wb_abort_valid", retire_valid, 0);

        run(32'hFFB00093, 1'b0, rd, data, ill, lat);
        model(32'hFFB00093, mrd, mdata, mill, mlat);
        check("recover_data", data, mdata);
        dbg_check(5'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
